// File: rtl/memory_arbiter.sv
// memory_arbiter
// Two-port round-robin arbiter and sequencer in front of the shared word memory.
// Port 0 is instruction fetch and port 1 is load/store. Only one transaction is
// in flight at a time. Out-of-range addresses are answered with an error
// response and never reach the memory.
//
//  state | meaning
//  ------+---------------------------------------------------------------
//  IDLE  | no transaction; arbitrate and latch the winning request
//  ISSUE | one cycle; read or write strobe driven from latched registers
//  WAIT  | read strobe held (reads only) until the memory responds
//  DONE  | one cycle; response/error/read data presented to granted port

module memory_arbiter #(
    parameter int unsigned MEMORY_SIZE = 4096
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        p0_read,
    input  logic        p0_write,
    input  logic [31:0] p0_address,
    input  logic [31:0] p0_write_data,
    output logic [31:0] p0_read_data,
    output logic        p0_response,
    output logic        p0_error,

    input  logic        p1_read,
    input  logic        p1_write,
    input  logic [31:0] p1_address,
    input  logic [31:0] p1_write_data,
    output logic [31:0] p1_read_data,
    output logic        p1_response,
    output logic        p1_error,

    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data,
    input  logic        mem_response,

    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;

    // Port id of the most recent grant; the other port wins the next tie.
    logic        last_grant;

    // Latched transaction
    logic        grant_q;
    logic        op_write_q;
    logic        err_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;

    // Arbitration results for the current cycle
    logic        p0_req;
    logic        p1_req;
    logic        req_any;
    logic        grant_sel;
    logic        sel_write;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        sel_err;

    assign p0_req  = p0_read | p0_write;
    assign p1_req  = p1_read | p1_write;
    assign req_any = p0_req | p1_req;

    // Round-robin pick and mux of the winning request fields
    always_comb begin
        grant_sel = 1'b0;
        if (p0_req && p1_req) begin
            grant_sel = ~last_grant;
        end else if (p1_req) begin
            grant_sel = 1'b1;
        end

        if (grant_sel) begin
            sel_write = p1_write;
            sel_addr  = p1_address;
            sel_wdata = p1_write_data;
        end else begin
            sel_write = p0_write;
            sel_addr  = p0_address;
            sel_wdata = p0_write_data;
        end

        // Full 32-bit compare so high address bits cannot alias into range.
        sel_err = (sel_addr >= 32'(MEMORY_SIZE));
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (req_any) begin
                    state_next = sel_err ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                state_next = WAIT;
            end
            WAIT: begin
                if (mem_response) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Request latch, grant history and read-data capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= 1'b1;
            grant_q    <= 1'b0;
            op_write_q <= 1'b0;
            err_q      <= 1'b0;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            rdata_q    <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_any) begin
                        last_grant <= grant_sel;
                        grant_q    <= grant_sel;
                        // Write takes precedence when both strobes are raised.
                        op_write_q <= sel_write;
                        err_q      <= sel_err;
                        addr_q     <= {sel_addr[31:2], 2'b00};
                        wdata_q    <= sel_wdata;
                        rdata_q    <= 32'h0;
                    end
                end
                WAIT: begin
                    if (mem_response) begin
                        rdata_q <= op_write_q ? 32'h0 : mem_read_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign mem_address    = addr_q;
    assign mem_write_data = wdata_q;

    // Strobes, busy and per-port responses decoded from state
    always_comb begin
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        busy         = (state != IDLE);
        p0_response  = 1'b0;
        p0_error     = 1'b0;
        p0_read_data = 32'h0;
        p1_response  = 1'b0;
        p1_error     = 1'b0;
        p1_read_data = 32'h0;
        case (state)
            ISSUE: begin
                mem_read  = ~op_write_q;
                mem_write = op_write_q;
            end
            WAIT: begin
                // Keep the read strobe up so combinational read data stays valid.
                mem_read = ~op_write_q;
            end
            DONE: begin
                if (grant_q) begin
                    p1_response  = 1'b1;
                    p1_error     = err_q;
                    p1_read_data = err_q ? 32'h0 : rdata_q;
                end else begin
                    p0_response  = 1'b1;
                    p0_error     = err_q;
                    p0_read_data = err_q ? 32'h0 : rdata_q;
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter with a small behavioural word memory.

module tb_memory_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        p0_read, p0_write, p1_read, p1_write;
    logic [31:0] p0_address, p0_write_data, p1_address, p1_write_data;
    logic [31:0] p0_read_data, p1_read_data;
    logic        p0_response, p0_error, p1_response, p1_error;
    logic        mem_read, mem_write, mem_response, busy;
    logic [31:0] mem_address, mem_write_data, mem_read_data;

    logic [31:0] mem [0:1023];
    logic        bd_we;
    logic [9:0]  bd_idx;
    logic [31:0] bd_val;
    int          stall;
    logic        mem_active;
    int          mem_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    memory_arbiter #(.MEMORY_SIZE(4096)) dut (
        .clk(clk), .rst(rst),
        .p0_read(p0_read), .p0_write(p0_write), .p0_address(p0_address),
        .p0_write_data(p0_write_data), .p0_read_data(p0_read_data),
        .p0_response(p0_response), .p0_error(p0_error),
        .p1_read(p1_read), .p1_write(p1_write), .p1_address(p1_address),
        .p1_write_data(p1_write_data), .p1_read_data(p1_read_data),
        .p1_response(p1_response), .p1_error(p1_error),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_write_data(mem_write_data), .mem_read_data(mem_read_data),
        .mem_response(mem_response), .busy(busy)
    );

    // Memory model: combinational read, write on strobe edge, registered response
    assign mem_read_data = mem_read ? mem[mem_address[11:2]] : 32'h0;

    always @(posedge clk) begin
        if (bd_we) mem[bd_idx] <= bd_val;
        else if (mem_write) mem[mem_address[11:2]] <= mem_write_data;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_response <= 1'b0;
            mem_active   <= 1'b0;
            mem_cnt      <= 0;
        end else begin
            mem_response <= 1'b0;
            if (!mem_active && (mem_read || mem_write) && !mem_response) begin
                if (stall == 0) mem_response <= 1'b1;
                else begin
                    mem_active <= 1'b1;
                    mem_cnt    <= stall;
                end
            end else if (mem_active) begin
                if (mem_cnt == 1) begin
                    mem_response <= 1'b1;
                    mem_active   <= 1'b0;
                end
                mem_cnt <= mem_cnt - 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [9:0] idx, input logic [31:0] val);
        bd_we = 1'b1; bd_idx = idx; bd_val = val;
        @(posedge clk);
        @(negedge clk);
        bd_we = 1'b0;
    endtask

    // Run one request on one port from a negedge in IDLE; latency counts
    // negedges after the request is raised.
    task automatic txn(input int port, input logic rd, input logic wr,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rdata, output logic err, output int lat,
                       output int nrd, output int nwr, output logic other);
        rdata = 32'h0; err = 1'b0; lat = 0; nrd = 0; nwr = 0; other = 1'b0;
        if (port == 0) begin
            p0_read = rd; p0_write = wr; p0_address = addr; p0_write_data = wdata;
        end else begin
            p1_read = rd; p1_write = wr; p1_address = addr; p1_write_data = wdata;
        end
        for (int k = 1; k <= 50; k++) begin
            @(negedge clk);
            if (mem_read) nrd++;
            if (mem_write) nwr++;
            if (port == 0) begin
                if (p1_response || p1_error || p1_read_data != 0) other = 1'b1;
                if (p0_response) begin
                    lat = k; rdata = p0_read_data; err = p0_error;
                    break;
                end
            end else begin
                if (p0_response || p0_error || p0_read_data != 0) other = 1'b1;
                if (p1_response) begin
                    lat = k; rdata = p1_read_data; err = p1_error;
                    break;
                end
            end
        end
        p0_read = 1'b0; p0_write = 1'b0; p1_read = 1'b0; p1_write = 1'b0;
        @(negedge clk);
    endtask

    logic [31:0] rdata;
    logic        err, other;
    int          lat, nrd, nwr;
    int          got [4];
    logic [31:0] gdat [4];
    int          ng;
    int          first_port;
    logic [31:0] first_data;

    initial begin
        rst = 1'b1; stall = 0; bd_we = 1'b0; bd_idx = '0; bd_val = '0;
        p0_read = 0; p0_write = 0; p0_address = 0; p0_write_data = 0;
        p1_read = 0; p1_write = 0; p1_address = 0; p1_write_data = 0;

        preload(10'd4,    32'hDEADBEEF);
        preload(10'd6,    32'h11111111);
        preload(10'd7,    32'h22222222);
        preload(10'd2,    32'h00000000);
        preload(10'd8,    32'h00000000);
        preload(10'd1023, 32'hCAFEF00D);

        chk("rst_busy",      {31'h0, busy},      32'h0);
        chk("rst_mem_read",  {31'h0, mem_read},  32'h0);
        chk("rst_mem_write", {31'h0, mem_write}, 32'h0);
        chk("rst_mem_addr",  mem_address,        32'h0);
        chk("rst_mem_wdata", mem_write_data,     32'h0);
        chk("rst_p0_resp",   {31'h0, p0_response}, 32'h0);
        chk("rst_p1_err",    {31'h0, p1_error},    32'h0);

        // Tie from reset: grants must alternate starting with port 0
        p0_read = 1'b1; p0_address = 32'h18;
        p1_read = 1'b1; p1_address = 32'h1C;
        rst = 1'b0;
        ng = 0;
        for (int k = 0; k < 60 && ng < 4; k++) begin
            @(negedge clk);
            if (p0_response && p1_response) chk("tie_both_resp", 32'h1, 32'h0);
            if (p0_response) begin
                got[ng] = 0; gdat[ng] = p0_read_data; ng++; p0_read = 1'b0;
            end else if (p1_response) begin
                got[ng] = 1; gdat[ng] = p1_read_data; ng++; p1_read = 1'b0;
            end else begin
                p0_read = 1'b1; p1_read = 1'b1;
            end
        end
        p0_read = 1'b0; p1_read = 1'b0;
        @(negedge clk);
        chk("tie_count", 32'(ng), 32'd4);
        chk("tie_order", {got[0][7:0], got[1][7:0], got[2][7:0], got[3][7:0]}, 32'h00010001);
        chk("tie_data0", gdat[0], 32'h11111111);
        chk("tie_data1", gdat[1], 32'h22222222);

        // Single read
        txn(0, 1'b1, 1'b0, 32'h10, 32'h0, rdata, err, lat, nrd, nwr, other);
        chk("rd_data",    rdata, 32'hDEADBEEF);
        chk("rd_err",     {31'h0, err}, 32'h0);
        chk("rd_latency", 32'(lat), 32'd3);
        chk("rd_strobes", 32'(nrd), 32'd2);
        chk("rd_nowrite", 32'(nwr), 32'd0);
        chk("rd_other",   {31'h0, other}, 32'h0);
        chk("rd_addr",    mem_address, 32'h10);
        chk("idle_busy",  {31'h0, busy}, 32'h0);

        // Write then read back on port 1
        txn(1, 1'b0, 1'b1, 32'h20, 32'h12345678, rdata, err, lat, nrd, nwr, other);
        chk("wr_data",    rdata, 32'h0);
        chk("wr_latency", 32'(lat), 32'd3);
        chk("wr_pulses",  32'(nwr), 32'd1);
        chk("wr_noread",  32'(nrd), 32'd0);
        chk("wr_mem",     mem[8], 32'h12345678);
        chk("wr_other",   {31'h0, other}, 32'h0);
        txn(1, 1'b1, 1'b0, 32'h20, 32'h0, rdata, err, lat, nrd, nwr, other);
        chk("wr_readback", rdata, 32'h12345678);

        // Out of range on port 1
        txn(1, 1'b1, 1'b0, 32'h1000, 32'h0, rdata, err, lat, nrd, nwr, other);
        chk("oor_err",     {31'h0, err}, 32'h1);
        chk("oor_latency", 32'(lat), 32'd1);
        chk("oor_data",    rdata, 32'h0);
        chk("oor_strobes", 32'(nrd + nwr), 32'd0);

        // Last in-range word, and a high address that would alias onto it
        txn(0, 1'b1, 1'b0, 32'hFFC, 32'h0, rdata, err, lat, nrd, nwr, other);
        chk("top_data", rdata, 32'hCAFEF00D);
        chk("top_err",  {31'h0, err}, 32'h0);
        txn(0, 1'b0, 1'b1, 32'hFFFFFFFC, 32'h55555555, rdata, err, lat, nrd, nwr, other);
        chk("hi_err",     {31'h0, err}, 32'h1);
        chk("hi_nowrite", 32'(nwr), 32'd0);
        chk("hi_mem",     mem[1023], 32'hCAFEF00D);

        // Read and write together is a write
        txn(0, 1'b1, 1'b1, 32'h8, 32'hA5A5A5A5, rdata, err, lat, nrd, nwr, other);
        chk("rw_data",   rdata, 32'h0);
        chk("rw_pulses", 32'(nwr), 32'd1);
        chk("rw_noread", 32'(nrd), 32'd0);
        chk("rw_mem",    mem[2], 32'hA5A5A5A5);

        // Slow memory: WAIT holds until the response arrives
        stall = 3;
        txn(1, 1'b1, 1'b0, 32'h10, 32'h0, rdata, err, lat, nrd, nwr, other);
        stall = 0;
        chk("slow_data",    rdata, 32'hDEADBEEF);
        chk("slow_latency", 32'(lat), 32'd6);
        chk("slow_strobes", 32'(nrd), 32'd5);

        // Reset while in WAIT, after a port-0 grant
        stall = 10;
        p0_read = 1'b1; p0_address = 32'h10;
        @(negedge clk);
        @(negedge clk);
        chk("mid_busy_pre",  {31'h0, busy}, 32'h1);
        chk("mid_read_pre",  {31'h0, mem_read}, 32'h1);
        #1 rst = 1'b1;
        #1;
        chk("mid_busy",  {31'h0, busy}, 32'h0);
        chk("mid_read",  {31'h0, mem_read}, 32'h0);
        chk("mid_write", {31'h0, mem_write}, 32'h0);
        chk("mid_resp",  {30'h0, p0_response, p1_response}, 32'h0);
        chk("mid_addr",  mem_address, 32'h0);
        p1_read = 1'b1; p1_address = 32'h1C;
        @(negedge clk);
        stall = 0;
        rst = 1'b0;
        first_port = -1; first_data = 32'h0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (p0_response) begin first_port = 0; first_data = p0_read_data; break; end
            if (p1_response) begin first_port = 1; first_data = p1_read_data; break; end
        end
        p0_read = 1'b0; p1_read = 1'b0;
        @(negedge clk);
        chk("post_rst_port", 32'(first_port), 32'd0);
        chk("post_rst_data", first_data, 32'hDEADBEEF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
